mips_next_pc_unit: RTL and testbench

- Program counter register plus next-address datapath for the single-cycle MIPS core.
- Each clock computes PC+4, a PC-relative branch target and a J-type jump target.
- Selects among them with two cascaded 32-bit 2:1 muxes (branch first, then jump), then registers the result.
- Built from the shared 32-bit adder and 32-bit 2:1 mux primitives. The clock source is external (bench clock generator).

---
 rtl/mips_next_pc_unit.sv | 120 ++++++++++++
 tb/tb_mips_next_pc_unit.sv | 135 +++++++++++++
 2 files changed

// File: rtl/mips_next_pc_unit.sv
`default_nettype none
//============================================================================
// Module      : mips_next_pc_unit (with helpers mips_adder32, mips_mux2_32)
// Description : Program counter register and next-address datapath for the
//               single-cycle MIPS core. Each cycle forms PC+4, a PC-relative
//               branch target and a J-type jump target, selects among them
//               (branch mux first, jump mux second) and registers the result.
// Ports       : clk             - system clock, rising-edge active
//               reset           - synchronous, active-high reset
//               current_address - registered PC (instruction fetch address)
//               jump_steps      - signed branch offset in words
//               select_branch   - 1 = take branch target
//               select_jump     - 1 = take jump target (beats select_branch)
//               instruction     - current instruction, [25:0] = jump index
// Revision    : 1.0 - initial release
//============================================================================

//----------------------------------------------------------------------------
// Shared 32-bit adder primitive: modulo 2^32, carry-out discarded.
//----------------------------------------------------------------------------
module mips_adder32 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_sum
);
    assign o_sum = i_a + i_b;
endmodule

//----------------------------------------------------------------------------
// Shared 32-bit 2:1 mux primitive: o_y = i_sel ? i_d1 : i_d0.
//----------------------------------------------------------------------------
module mips_mux2_32 (
    input  logic [31:0] i_d0,
    input  logic [31:0] i_d1,
    input  logic        i_sel,
    output logic [31:0] o_y
);
    assign o_y = i_sel ? i_d1 : i_d0;
endmodule

//----------------------------------------------------------------------------
// Top level
//----------------------------------------------------------------------------
module mips_next_pc_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] current_address,
    input  logic [31:0] jump_steps,
    input  logic        select_branch,
    input  logic        select_jump,
    input  logic [31:0] instruction
);

    localparam logic [31:0] c_pc_step = 32'd4;

    logic [31:0] r_pc_q;
    logic [31:0] w_pc_d;
    logic [31:0] w_addr_plus4;
    logic [31:0] w_branch_offset;
    logic [31:0] w_branch_addr;
    logic [31:0] w_branch_mux;
    logic [31:0] w_jump_addr;
    logic [31:0] w_next_address;
    logic        w_unused_bits;

    // Word offset to byte offset: the two top bits of the offset fall off,
    // which keeps the arithmetic two's-complement within 32 bits.
    assign w_branch_offset = {jump_steps[29:0], 2'b00};

    // J-type target keeps the 256 MB region of the delay-slot address.
    assign w_jump_addr = {w_addr_plus4[31:28], instruction[25:0], 2'b00};

    // Bits that the address arithmetic deliberately ignores.
    assign w_unused_bits = ^{instruction[31:26], jump_steps[31:30]};

    mips_adder32 u_add_plus4 (
        .i_a   (r_pc_q),
        .i_b   (c_pc_step),
        .o_sum (w_addr_plus4)
    );

    mips_adder32 u_add_branch (
        .i_a   (w_addr_plus4),
        .i_b   (w_branch_offset),
        .o_sum (w_branch_addr)
    );

    mips_mux2_32 u_mux_branch (
        .i_d0  (w_addr_plus4),
        .i_d1  (w_branch_addr),
        .i_sel (select_branch),
        .o_y   (w_branch_mux)
    );

    // Jump mux sits after the branch mux, so a jump overrides a branch.
    mips_mux2_32 u_mux_jump (
        .i_d0  (w_branch_mux),
        .i_d1  (w_jump_addr),
        .i_sel (select_jump),
        .o_y   (w_next_address)
    );

    always_comb begin
        w_pc_d = w_next_address;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_q <= RESET_ADDR;
        end else begin
            r_pc_q <= w_pc_d;
        end
    end

    assign current_address = r_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_next_pc_unit.sv
`default_nettype none
//============================================================================
// Module      : tb_mips_next_pc_unit
// Description : Directed self-checking bench for mips_next_pc_unit. Each step
//               drives inputs on the falling edge, pushes the expected PC
//               into a scoreboard queue, and pops/compares it 1 ns after the
//               following rising edge.
// Revision    : 1.0 - initial release
//============================================================================
module tb_mips_next_pc_unit;

    logic        clk;
    logic        reset;
    logic [31:0] current_address;
    logic [31:0] jump_steps;
    logic        select_branch;
    logic        select_jump;
    logic [31:0] instruction;

    int unsigned n_cmp;
    int unsigned n_fail;
    logic [31:0] exp_q[$];

    mips_next_pc_unit #(
        .RESET_ADDR (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .current_address (current_address),
        .jump_steps      (jump_steps),
        .select_branch   (select_branch),
        .select_jump     (select_jump),
        .instruction     (instruction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_now(input string tag, input logic [31:0] exp);
        n_cmp++;
        assert (current_address === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, current_address, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] exp;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s: observed empty scoreboard expected one entry", tag);
        end else begin
            exp = exp_q.pop_front();
            check_now(tag, exp);
        end
    endtask

    // One clock step: drive on negedge, record expectation, check after posedge.
    task automatic step(input string tag, input logic rst, input logic sb,
                        input logic sj, input logic [31:0] steps,
                        input logic [31:0] instr, input logic [31:0] exp);
        @(negedge clk);
        reset         = rst;
        select_branch = sb;
        select_jump   = sj;
        jump_steps    = steps;
        instruction   = instr;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

    initial begin
        n_cmp         = 0;
        n_fail        = 0;
        reset         = 1'b1;
        select_branch = 1'b0;
        select_jump   = 1'b0;
        jump_steps    = 32'd0;
        instruction   = 32'd0;

        // Reset then sequential fetch.
        step("reset", 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            step("seq", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'(4 * i));
        end

        // Forward branch from 20, then sequential.
        step("br_fwd", 1'b0, 1'b1, 1'b0, 32'd100, 32'd0, 32'd424);
        step("after_br", 1'b0, 1'b0, 1'b0, 32'd100, 32'd0, 32'd428);

        // Small and backward branches.
        step("br_small", 1'b0, 1'b1, 1'b0, 32'd10, 32'd0, 32'd472);
        step("br_m1", 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'd472);
        step("br_m2", 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'd0, 32'd468);

        // Branch into the 0x1000_0000 region: 468 + 4 + 4*0x03FF_FF8A.
        step("br_far", 1'b0, 1'b1, 1'b0, 32'h03FF_FF8A, 32'd0, 32'h1000_0000);

        // Jump with branch also selected: jump wins, upper nibble from PC+4.
        step("jump_pri", 1'b0, 1'b1, 1'b1, 32'd100, 32'h0800_0010, 32'h1000_0040);

        // Branch to the top word: 0x1000_0044 + 4*0x3BFF_FFEE = 0xFFFF_FFFC.
        step("br_top", 1'b0, 1'b1, 1'b0, 32'h3BFF_FFEE, 32'd0, 32'hFFFF_FFFC);
        step("wrap", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);

        // Run up to 44.
        for (int i = 1; i <= 11; i++) begin
            step("seq2", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'(4 * i));
        end

        // Reset asserted between edges must not act until the next edge.
        @(negedge clk);
        reset         = 1'b1;
        select_branch = 1'b1;
        jump_steps    = 32'd100;
        #2;
        check_now("rst_sync", 32'd44);
        exp_q.push_back(32'd0);
        @(posedge clk);
        #1;
        pop_check("rst_mid");

        // Release reset: first edge loads 4.
        step("rst_rel", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
